// File: rtl/midi_event_framer_pkg.sv
// Shared MIDI framer definitions: status nibbles, parser states, event layout.
package midi_event_framer_pkg;

  localparam logic [3:0] NIB_NOTE_OFF       = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON        = 4'h9;
  localparam logic [3:0] NIB_POLY_PRESSURE  = 4'hA;
  localparam logic [3:0] NIB_CONTROL_CHANGE = 4'hB;
  localparam logic [3:0] NIB_PROGRAM_CHANGE = 4'hC;
  localparam logic [3:0] NIB_CHAN_PRESSURE  = 4'hD;
  localparam logic [3:0] NIB_PITCH_BEND     = 4'hE;
  localparam logic [3:0] NIB_SYSTEM         = 4'hF;

  localparam int EVENT_W = 22;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_P1 = 2'd1,
    ST_WAIT_P2 = 2'd2,
    ST_SKIP    = 2'd3
  } parser_state_e;

  typedef struct packed {
    logic [7:0] command;
    logic [6:0] param1;
    logic [6:0] param2;
  } midi_event_t;

  // Number of data bytes following a channel-voice status; 0 for system bytes.
  function automatic logic [1:0] param_count(input logic [7:0] status);
    logic [1:0] cnt;
    case (status[7:4])
      NIB_NOTE_OFF, NIB_NOTE_ON, NIB_POLY_PRESSURE,
      NIB_CONTROL_CHANGE, NIB_PITCH_BEND:     cnt = 2'd2;
      NIB_PROGRAM_CHANGE, NIB_CHAN_PRESSURE:  cnt = 2'd1;
      NIB_SYSTEM:                             cnt = 2'd0;
      default:                                cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/midi_event_framer_fifo.sv
// Synchronous show-ahead event FIFO; head word is presented whenever not empty.
module midi_event_framer_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic               pop_ok_s;
  logic               push_ok_s;

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pop_ok_s  = pop & (level_r != {LEVEL_W{1'b0}});
  assign push_ok_s = push & ((level_r != FULL_LEVEL) | pop_ok_s);

  // Storage, pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LEVEL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LEVEL_W'(1);
        2'b01:   level_r <= level_r - LEVEL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (level_r == FULL_LEVEL);
  assign empty = (level_r == {LEVEL_W{1'b0}});
  assign level = level_r;

endmodule

// File: rtl/midi_event_framer.sv
// MIDI byte-to-event framer with running status, channel filter and event FIFO.
// Optional MIDI_FRAMER_REALTIME_EN: enqueue realtime bytes 0xF8-0xFF as 1-byte events.
module midi_event_framer
  import midi_event_framer_pkg::*;
#(
  parameter int          FIFO_DEPTH          = 8,
  parameter logic [15:0] CHANNEL_MASK        = 16'hFFFF,
  parameter bit          NOTE_ON_ZERO_IS_OFF = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          evt_valid,
  output logic [7:0]                    evt_command,
  output logic [6:0]                    evt_param1,
  output logic [6:0]                    evt_param2,
  input  logic                          evt_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

`ifdef MIDI_FRAMER_REALTIME_EN
  localparam bit REALTIME_EN = 1'b1;
`else
  localparam bit REALTIME_EN = 1'b0;
`endif

  parser_state_e state_r, state_s;
  logic [7:0]    status_r, status_s;
  logic [6:0]    param1_r, param1_s;
  logic          complete_s;
  logic [6:0]    cmp_p1_s;
  logic [6:0]    cmp_p2_s;
  logic          realtime_s;
  logic          push_s;
  midi_event_t   push_evt_s;
  midi_event_t   head_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          overflow_r;

  // Parser state, running status and latched first parameter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      status_r <= 8'h00;
      param1_r <= 7'h00;
    end else begin
      state_r  <= state_s;
      status_r <= status_s;
      param1_r <= param1_s;
    end
  end

  // Next-state decode of each received byte; flags a completed channel message.
  always_comb begin
    state_s    = state_r;
    status_s   = status_r;
    param1_s   = param1_r;
    complete_s = 1'b0;
    cmp_p1_s   = 7'h00;
    cmp_p2_s   = 7'h00;
    realtime_s = 1'b0;
    if (!rx_valid) begin
      state_s = state_r;
    end else if (rx_data >= 8'hF8) begin
      realtime_s = REALTIME_EN;
    end else if (rx_data >= 8'hF0) begin
      status_s = 8'h00;
      state_s  = (rx_data == 8'hF7) ? ST_IDLE : ST_SKIP;
    end else if (rx_data[7]) begin
      status_s = rx_data;
      state_s  = ST_WAIT_P1;
    end else begin
      case (state_r)
        ST_WAIT_P1: begin
          if (param_count(status_r) == 2'd1) begin
            complete_s = 1'b1;
            cmp_p1_s   = rx_data[6:0];
          end else begin
            param1_s = rx_data[6:0];
            state_s  = ST_WAIT_P2;
          end
        end
        ST_WAIT_P2: begin
          complete_s = 1'b1;
          cmp_p1_s   = param1_r;
          cmp_p2_s   = rx_data[6:0];
          state_s    = ST_WAIT_P1;
        end
        default: state_s = state_r;
      endcase
    end
  end

  // Event assembly: realtime bypasses the channel mask; zero-velocity note-on becomes note-off.
  always_comb begin
    push_s     = 1'b0;
    push_evt_s = '{command: 8'h00, param1: 7'h00, param2: 7'h00};
    if (realtime_s) begin
      push_s     = 1'b1;
      push_evt_s = '{command: rx_data, param1: 7'h00, param2: 7'h00};
    end else if (complete_s && CHANNEL_MASK[status_r[3:0]]) begin
      push_s = 1'b1;
      if (NOTE_ON_ZERO_IS_OFF && (status_r[7:4] == NIB_NOTE_ON) && (cmp_p2_s == 7'h00)) begin
        push_evt_s = '{command: {NIB_NOTE_OFF, status_r[3:0]}, param1: cmp_p1_s, param2: cmp_p2_s};
      end else begin
        push_evt_s = '{command: status_r, param1: cmp_p1_s, param2: cmp_p2_s};
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s = evt_ack & ~fifo_empty_s;

  // Sticky overflow: an event was lost because the FIFO was full with no pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  midi_event_framer_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (push_evt_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign evt_valid   = ~fifo_empty_s;
  assign evt_command = head_s.command;
  assign evt_param1  = head_s.param1;
  assign evt_param2  = head_s.param2;
  assign overflow    = overflow_r;

endmodule
